efuse_boot_loader: RTL and testbench
====================================

Name: efuse_boot_loader

Overview:
- Boot-time sequencer and bus owner for the eFuse APB interface.
- After reset it masters the eFuse APB slave and performs these steps:
  - enter read mode;
  - read NUM_WORDS consecutive eFuse words into shadow registers;
  - return the macro to idle.
- It then hands the eFuse APB port to the SoC APB bus as a passthrough.
- Sits between the SoC APB interconnect and the eFuse APB interface. The shadow outputs feed trim and config logic.

Parameters:
- APB_ADDR_WIDTH, 12, address width of both APB ports.
- NUM_WORDS, 4, number of eFuse words shadowed (1..32).
- START_WORD, 0, first eFuse word index (START_WORD+NUM_WORDS <= 128).
- TIMEOUT_CYCLES, 4096, maximum cycles a single master transfer waits for m_pready.

Ports:
- PCLK  in  1  clock.
- PRESETN  in  1  reset, asynchronous, active-low.
- s_paddr  in  APB_ADDR_WIDTH  SoC-side address.
- s_pwdata  in  32  SoC-side write data.
- s_pwrite  in  1  SoC-side write.
- s_psel  in  1  SoC-side select.
- s_penable  in  1  SoC-side enable.
- s_prdata  out  32  SoC-side read data.
- s_pready  out  1  SoC-side ready.
- s_pslverr  out  1  SoC-side error.
- m_paddr  out  APB_ADDR_WIDTH  eFuse-side address.
- m_pwdata  out  32  eFuse-side write data.
- m_pwrite  out  1  eFuse-side write.
- m_psel  out  1  eFuse-side select.
- m_penable  out  1  eFuse-side enable.
- m_prdata  in  32  eFuse-side read data.
- m_pready  in  1  eFuse-side ready.
- m_pslverr  in  1  eFuse-side error.
- shadow_o  out  NUM_WORDS*32  shadowed words; word i occupies bits [32i+31:32i].
- boot_done_o  out  1  sequence finished and bus released to SoC.
- boot_err_o  out  1  sequence aborted by timeout or slave error.

Behaviour:
- Reset values:
  - FSM in S_RST.
  - shadow_o=0, boot_done_o=0, boot_err_o=0.
  - All m_* outputs 0; s_pready=0, s_prdata=0, s_pslverr=0.
- eFuse address map:
  - CMD register at 0x000; write 0x1 = enter read mode, write 0x4 = go idle.
  - Word k is read at 0x200 + 4*k.
- Master transfers are APB3:
  - SETUP cycle: m_psel=1, m_penable=0.
  - Then ACCESS: m_penable=1, held with stable addr/data until m_pready=1.
  - m_prdata is sampled in the cycle m_pready=1.
  - There is no idle cycle between back-to-back transfers: the next SETUP follows directly.
- FSM states:
  - S_RST: one cycle -> S_CMD_RD.
  - S_CMD_RD: write 0x1 to 0x000 -> S_READ with idx=0.
  - S_READ: read 0x200+4*(START_WORD+idx). On m_pready, shadow[idx] <= m_prdata. If idx==NUM_WORDS-1 -> S_CMD_IDLE, else idx++.
  - S_CMD_IDLE: write 0x4 to 0x000 -> S_DONE.
  - S_DONE: boot_done_o=1; terminal until reset.
  - S_ERR: boot_done_o=1, boot_err_o=1; terminal until reset.
- Timeout and errors:
  - A per-transfer counter clears at SETUP and increments each ACCESS cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without m_pready -> S_ERR. m_psel/m_penable drop the next cycle.
  - m_pslverr=1 together with m_pready -> S_ERR. The shadow word is not written.
  - On error no idle command is sent, and shadows already captured are kept.
- Arbitration:
  - Before S_DONE/S_ERR, the SoC port is stalled: s_pready=0 and s_pslverr=0. No SoC signal reaches the eFuse port.
  - Ownership transfers in the cycle boot_done_o rises.
  - From then on m_* = s_*, s_prdata = m_prdata, s_pready = m_pready, s_pslverr = m_pslverr.
  - Exception, pending access: if s_psel&s_penable is already high at handover, the first forwarded cycle drives m_penable=0 (inserted SETUP). Full passthrough applies from the next cycle.
- Shadow registers only change in S_READ and are never writable from the SoC.
- Async reset mid-sequence:
  - Restarts from S_RST and clears the shadows.
  - Any eFuse transfer in flight is simply abandoned (the eFuse IF is reset by the same PRESETN).

Decomposition:
- Package efuse_boot_pkg:
  - state enum (S_RST, S_CMD_RD, S_READ, S_CMD_IDLE, S_DONE, S_ERR);
  - constants EFUSE_CMD_ADDR=0x000, EFUSE_DATA_BASE=0x200, CMD_READ=0x1, CMD_IDLE=0x4.
- One sub-module, efuse_apb_xfer: a single-transfer APB master engine.
  - Inputs: req/addr/wdata/write.
  - Outputs: done/rdata/err.
  - Contains the SETUP/ACCESS sequencing and the timeout counter.
- The top level holds the FSM, shadows, index counter and arbitration mux.

Test Plan:
- Reset release with a behavioural eFuse slave (PREADY after 7 cycles, word k = 0xA5000000+k), NUM_WORDS=4 -> master sequence is:
  - write 0x1 to 0x000;
  - reads of 0x200, 0x204, 0x208, 0x20C;
  - write 0x4 to 0x000.
  - Result: shadow_o = {0xA5000003, 0xA5000002, 0xA5000001, 0xA5000000}, boot_done_o=1, boot_err_o=0.
- SoC read of 0x004 issued 3 cycles after reset release -> s_pready stays 0 until handover. At handover there is one inserted m_penable=0 cycle, then the slave's CFG value returns on s_prdata.
- Slave never asserts PREADY on the 2nd data read, TIMEOUT_CYCLES=16 -> S_ERR 16 ACCESS cycles after SETUP. Expected: boot_err_o=1, boot_done_o=1, shadow[0] valid, shadow[1..3]=0, no idle command issued.
- Slave returns m_pslverr=1 on the CMD write -> S_ERR. No data reads occur and all shadows are 0.
- PRESETN pulsed low during the 3rd read -> all outputs return to reset values asynchronously. After release the full sequence repeats from the CMD write and completes correctly.
- START_WORD=10, NUM_WORDS=1 -> a single read at 0x228. Back-to-back SETUP timing shows no idle cycle between transfers.

Source files
------------

// File: rtl/efuse_boot_pkg.sv
// Shared definitions for the eFuse boot loader.
// Contents: boot sequencer state encoding and eFuse APB register map constants.
package efuse_boot_pkg;

    typedef enum logic [2:0] {
        S_RST,
        S_CMD_RD,
        S_READ,
        S_CMD_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] EFUSE_CMD_ADDR  = 32'h0000_0000;
    localparam logic [31:0] EFUSE_DATA_BASE = 32'h0000_0200;
    localparam logic [31:0] CMD_READ        = 32'h0000_0001;
    localparam logic [31:0] CMD_IDLE        = 32'h0000_0004;

endpackage

// File: rtl/efuse_apb_xfer.sv
// Single-transfer APB3 master engine.
// Ports:
//   PCLK, PRESETN                  clock, async active-low reset
//   req, addr, wdata, write        transfer request, held until done
//   done, rdata, err               completion pulse, read data, slave error/timeout
//   paddr, pwdata, pwrite, psel,
//   penable                        APB master outputs
//   prdata, pready, pslverr        APB master inputs
// psel follows req directly, so a new request presented in the cycle after
// done starts its SETUP phase immediately with no idle cycle in between.
module efuse_apb_xfer #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              write,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             access_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    assign timeout = access_q & ~pready & (cnt_q == CNT_LAST);
    assign done    = access_q & (pready | timeout);
    assign err     = access_q & ((pready & pslverr) | timeout);
    assign rdata   = prdata;

    assign paddr   = addr;
    assign pwdata  = wdata;
    assign pwrite  = write;
    assign psel    = req;
    assign penable = access_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            access_q <= 1'b0;
            cnt_q    <= '0;
        end else if (req && !access_q) begin
            access_q <= 1'b1;
            cnt_q    <= '0;
        end else if (access_q) begin
            if (done) begin
                access_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/efuse_boot_loader.sv
// Boot-time eFuse sequencer and APB bus owner.
// After reset it writes the read-mode command, shadows NUM_WORDS eFuse words,
// writes the idle command and then hands the eFuse APB port to the SoC.
// Ports:
//   PCLK, PRESETN        clock, async active-low reset
//   s_*                  SoC-side APB slave port (stalled until handover)
//   m_*                  eFuse-side APB master port
//   shadow_o             shadowed words, word i at [32i+31:32i]
//   boot_done_o          sequence ended, bus owned by SoC
//   boot_err_o           sequence aborted by timeout or slave error
module efuse_boot_loader
    import efuse_boot_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_WORDS      = 4,
    parameter int unsigned START_WORD     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      PCLK,
    input  logic                      PRESETN,
    input  logic [APB_ADDR_WIDTH-1:0] s_paddr,
    input  logic [31:0]               s_pwdata,
    input  logic                      s_pwrite,
    input  logic                      s_psel,
    input  logic                      s_penable,
    output logic [31:0]               s_prdata,
    output logic                      s_pready,
    output logic                      s_pslverr,
    output logic [APB_ADDR_WIDTH-1:0] m_paddr,
    output logic [31:0]               m_pwdata,
    output logic                      m_pwrite,
    output logic                      m_psel,
    output logic                      m_penable,
    input  logic [31:0]               m_prdata,
    input  logic                      m_pready,
    input  logic                      m_pslverr,
    output logic [NUM_WORDS*32-1:0]   shadow_o,
    output logic                      boot_done_o,
    output logic                      boot_err_o
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [NUM_WORDS*32-1:0]   shadow_q;
    logic                      done_q;
    logic                      err_q;
    logic                      handed_q;

    logic                      x_req;
    logic                      x_write;
    logic [APB_ADDR_WIDTH-1:0] x_addr;
    logic [31:0]               x_wdata;
    logic                      x_done;
    logic                      x_err;
    logic [31:0]               x_rdata;
    logic [31:0]               word_addr;

    logic [APB_ADDR_WIDTH-1:0] e_paddr;
    logic [31:0]               e_pwdata;
    logic                      e_pwrite;
    logic                      e_psel;
    logic                      e_penable;
    logic                      hold_setup;

    // Transfer request decoded from the current state.
    always_comb begin
        x_req     = 1'b0;
        x_write   = 1'b0;
        x_addr    = '0;
        x_wdata   = '0;
        word_addr = EFUSE_DATA_BASE + ((32'(START_WORD) + 32'(idx)) << 2);
        case (state)
            S_CMD_RD: begin
                x_req   = 1'b1;
                x_write = 1'b1;
                x_addr  = APB_ADDR_WIDTH'(EFUSE_CMD_ADDR);
                x_wdata = CMD_READ;
            end
            S_READ: begin
                x_req  = 1'b1;
                x_addr = APB_ADDR_WIDTH'(word_addr);
            end
            S_CMD_IDLE: begin
                x_req   = 1'b1;
                x_write = 1'b1;
                x_addr  = APB_ADDR_WIDTH'(EFUSE_CMD_ADDR);
                x_wdata = CMD_IDLE;
            end
            default: ;
        endcase
    end

    efuse_apb_xfer #(
        .ADDR_W         (APB_ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .req     (x_req),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .write   (x_write),
        .done    (x_done),
        .rdata   (x_rdata),
        .err     (x_err),
        .paddr   (e_paddr),
        .pwdata  (e_pwdata),
        .pwrite  (e_pwrite),
        .psel    (e_psel),
        .penable (e_penable),
        .prdata  (m_prdata),
        .pready  (m_pready),
        .pslverr (m_pslverr)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state    <= S_RST;
            idx      <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            handed_q <= 1'b0;
        end else begin
            handed_q <= done_q;
            case (state)
                S_RST: state <= S_CMD_RD;
                S_CMD_RD: begin
                    if (x_done && x_err) begin
                        state  <= S_ERR;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (x_done) begin
                        state <= S_READ;
                        idx   <= '0;
                    end
                end
                S_READ: begin
                    if (x_done && x_err) begin
                        state  <= S_ERR;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (x_done) begin
                        shadow_q[32*idx +: 32] <= x_rdata;
                        if (idx == IDX_W'(NUM_WORDS - 1)) begin
                            state <= S_CMD_IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_CMD_IDLE: begin
                    if (x_done && x_err) begin
                        state  <= S_ERR;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (x_done) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: ;
                S_ERR:  ;
                default: state <= S_RST;
            endcase
        end
    end

    // A SoC access already in ACCESS at handover is replayed to the eFuse as a
    // SETUP cycle first; its ready/error is held off for that cycle so the SoC
    // cannot complete against a slave that has only seen SETUP.
    assign hold_setup = done_q & ~handed_q & s_psel & s_penable;

    always_comb begin
        if (done_q) begin
            m_paddr   = s_paddr;
            m_pwdata  = s_pwdata;
            m_pwrite  = s_pwrite;
            m_psel    = s_psel;
            m_penable = s_penable & ~hold_setup;
            s_prdata  = m_prdata;
            s_pready  = m_pready & ~hold_setup;
            s_pslverr = m_pslverr & ~hold_setup;
        end else begin
            m_paddr   = e_paddr;
            m_pwdata  = e_pwdata;
            m_pwrite  = e_pwrite;
            m_psel    = e_psel;
            m_penable = e_penable;
            s_prdata  = '0;
            s_pready  = 1'b0;
            s_pslverr = 1'b0;
        end
    end

    assign shadow_o    = shadow_q;
    assign boot_done_o = done_q;
    assign boot_err_o  = err_q;

endmodule

// File: tb/tb_efuse_boot_loader.sv
// Scoreboard bench: a reference plan of eFuse transfers and shadow contents is
// pushed on each boot; monitors pop and compare as the DUT completes transfers.
module tb_efuse_boot_loader;

    localparam int AW  = 12;
    localparam int NW  = 4;
    localparam int SW  = 0;
    localparam int TO  = 16;
    localparam int SW1 = 10;
    localparam logic [31:0] CFG_RST = 32'h5A5A_1234;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   data;
    } xfer_t;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic PRESETN, rst1_n;

    logic [AW-1:0] s_paddr;  logic [31:0] s_pwdata; logic s_pwrite, s_psel, s_penable;
    logic [31:0] s_prdata;   logic s_pready, s_pslverr;
    logic [AW-1:0] m_paddr;  logic [31:0] m_pwdata; logic m_pwrite, m_psel, m_penable;
    logic [31:0] m_prdata;   logic m_pready, m_pslverr;
    logic [NW*32-1:0] shadow; logic boot_done, boot_err;

    logic [AW-1:0] d1_s_paddr; logic [31:0] d1_s_pwdata; logic d1_s_pwrite, d1_s_psel, d1_s_penable;
    logic [31:0] d1_s_prdata;  logic d1_s_pready, d1_s_pslverr;
    logic [AW-1:0] d1_m_paddr; logic [31:0] d1_m_pwdata; logic d1_m_pwrite, d1_m_psel, d1_m_penable;
    logic [31:0] d1_m_prdata;  logic d1_m_pready, d1_m_pslverr;
    logic [31:0] d1_shadow;    logic d1_done, d1_err;

    efuse_boot_loader #(.APB_ADDR_WIDTH(AW), .NUM_WORDS(NW), .START_WORD(SW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite), .s_psel(s_psel),
        .s_penable(s_penable), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite), .m_psel(m_psel),
        .m_penable(m_penable), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .shadow_o(shadow), .boot_done_o(boot_done), .boot_err_o(boot_err));

    efuse_boot_loader #(.APB_ADDR_WIDTH(AW), .NUM_WORDS(1), .START_WORD(SW1), .TIMEOUT_CYCLES(TO)) dut1 (
        .PCLK(PCLK), .PRESETN(rst1_n),
        .s_paddr(d1_s_paddr), .s_pwdata(d1_s_pwdata), .s_pwrite(d1_s_pwrite), .s_psel(d1_s_psel),
        .s_penable(d1_s_penable), .s_prdata(d1_s_prdata), .s_pready(d1_s_pready), .s_pslverr(d1_s_pslverr),
        .m_paddr(d1_m_paddr), .m_pwdata(d1_m_pwdata), .m_pwrite(d1_m_pwrite), .m_psel(d1_m_psel),
        .m_penable(d1_m_penable), .m_prdata(d1_m_prdata), .m_pready(d1_m_pready), .m_pslverr(d1_m_pslverr),
        .shadow_o(d1_shadow), .boot_done_o(d1_done), .boot_err_o(d1_err));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural eFuse slave (dut) ----------------
    logic [31:0] mem [128];
    int  lat_cfg = 7;
    bit  lat_rand = 0, hang_en = 0, err_en = 0;
    int  hang_idx = 0, err_idx = 0;
    int  acc_cnt, cur_lat, xfer_no, hang_acc;
    logic [31:0] cfg_reg;
    logic hang_now;

    assign hang_now  = hang_en && !boot_done && (xfer_no == hang_idx);
    assign m_pready  = m_psel && m_penable && !hang_now && (acc_cnt >= cur_lat);
    assign m_pslverr = m_pready && err_en && !boot_done && (xfer_no == err_idx);

    always_comb begin
        if (m_paddr >= 12'h200) m_prdata = mem[int'((m_paddr - 12'h200) >> 2)];
        else if (m_paddr == 12'h004) m_prdata = cfg_reg;
        else m_prdata = 32'h0;
    end

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            acc_cnt <= 0; xfer_no <= 0; hang_acc <= 0; cur_lat <= lat_cfg; cfg_reg <= CFG_RST;
        end else if (m_psel && m_penable) begin
            if (m_pready) begin
                acc_cnt <= 0;
                xfer_no <= xfer_no + 1;
                cur_lat <= lat_rand ? int'($urandom_range(0, 5)) : lat_cfg;
                if (m_pwrite && !m_pslverr && m_paddr == 12'h004) cfg_reg <= m_pwdata;
            end else begin
                acc_cnt <= acc_cnt + 1;
                if (hang_now) hang_acc <= hang_acc + 1;
            end
        end
    end

    // ---------------- zero-wait slave (dut1) ----------------
    assign d1_m_pready  = d1_m_psel && d1_m_penable;
    assign d1_m_pslverr = 1'b0;
    always_comb begin
        if (d1_m_paddr >= 12'h200) d1_m_prdata = mem[int'((d1_m_paddr - 12'h200) >> 2)];
        else d1_m_prdata = 32'h0;
    end

    // ---------------- reference model / scoreboard ----------------
    xfer_t exp_m[$];
    xfer_t exp1[$];
    logic [31:0] exp_soc[$];
    logic [NW*32-1:0] exp_shadow;
    logic [31:0] model_cfg;

    // kind: 0 clean boot, 1 slave error on transfer f, 2 transfer f never ready.
    // Transfer 0 is the read-mode command, 1..NW the word reads, NW+1 the idle command.
    task automatic plan(input int kind, input int f, input int limit);
        int last;
        xfer_t x;
        exp_m.delete();
        last = (kind == 0) ? NW + 1 : ((kind == 1) ? f : f - 1);
        if (limit < last) last = limit;
        for (int t = 0; t <= last; t++) begin
            if (t == 0) begin
                x.addr = 12'h000; x.wr = 1'b1; x.data = 32'h1;
            end else if (t <= NW) begin
                x.addr = AW'(12'h200 + 4 * (SW + t - 1)); x.wr = 1'b0; x.data = mem[SW + t - 1];
            end else begin
                x.addr = 12'h000; x.wr = 1'b1; x.data = 32'h4;
            end
            exp_m.push_back(x);
        end
        for (int j = 0; j < NW; j++)
            exp_shadow[j*32 +: 32] = (kind == 0 || j + 1 < f) ? mem[SW + j] : 32'h0;
    endtask

    bit prev_done = 0, prev_cmpl = 0;
    always @(negedge PCLK) begin
        xfer_t e;
        logic [31:0] d;
        if (!PRESETN) begin
            prev_done <= 1'b0;
            prev_cmpl <= 1'b0;
        end else begin
            if (!boot_done && s_psel) check("soc_stall", {s_pready, s_pslverr}, 2'b00);
            if (boot_done && !prev_done && s_psel && s_penable)
                check("handover_setup", {m_psel, m_penable, s_pready, m_paddr}, {1'b1, 1'b0, 1'b0, s_paddr});
            if (prev_cmpl && !boot_done) check("back_to_back", {m_psel, m_penable}, 2'b10);
            if (!boot_done && m_psel && m_penable && m_pready) begin
                if (exp_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_xfer: got unplanned transfer addr %0h expected none", m_paddr);
                end else begin
                    e = exp_m.pop_front();
                    check("m_xfer", {m_paddr, m_pwrite, m_pwrite ? m_pwdata : m_prdata}, e);
                end
            end
            if (boot_done && s_psel && s_penable && s_pready && !s_pwrite) begin
                if (exp_soc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL soc_read: got unplanned read %0h expected none", s_prdata);
                end else begin
                    d = exp_soc.pop_front();
                    check("soc_read", s_prdata, d);
                end
            end
            prev_cmpl <= !boot_done && m_psel && m_penable && m_pready;
            prev_done <= boot_done;
        end
    end

    int d1_psel_cycles = 0, d1_span = 0;
    bit d1_started = 0;
    always @(negedge PCLK) begin
        xfer_t e;
        if (rst1_n && !d1_done) begin
            if (d1_m_psel || d1_started) d1_span <= d1_span + 1;
            if (d1_m_psel) begin
                d1_started     <= 1'b1;
                d1_psel_cycles <= d1_psel_cycles + 1;
            end
            if (d1_m_psel && d1_m_penable && d1_m_pready) begin
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d1_xfer: got unplanned transfer addr %0h expected none", d1_m_paddr);
                end else begin
                    e = exp1.pop_front();
                    check("d1_xfer", {d1_m_paddr, d1_m_pwrite, d1_m_pwrite ? d1_m_pwdata : d1_m_prdata}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic soc_xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        s_paddr = a; s_pwrite = wr; s_pwdata = d; s_psel = 1'b1; s_penable = 1'b0;
        @(posedge PCLK); #1 s_penable = 1'b1;
        n = 0;
        do begin @(negedge PCLK); n++; end while (!s_pready && n < 4000);
        if (!s_pready) begin
            checks++; errors++;
            $display("FAIL soc_wait: got no s_pready expected completion");
        end
        @(posedge PCLK); #1 s_psel = 1'b0; s_penable = 1'b0;
    endtask

    task automatic check_reset_state();
        check("reset_outputs", {m_paddr, m_pwdata, m_pwrite, m_psel, m_penable, s_prdata,
                                s_pready, s_pslverr, boot_done, boot_err}, '0);
        check("reset_shadow", shadow, '0);
    endtask

    task automatic start_boot(input int kind, input int f, input int limit);
        @(posedge PCLK); #1;
        hang_en = (kind == 2); hang_idx = f;
        err_en  = (kind == 1); err_idx  = f;
        PRESETN = 1'b0;
        #1 check_reset_state();
        plan(kind, f, limit);
        model_cfg = CFG_RST;
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
    endtask

    task automatic finish_boot(input int kind, input int nsoc);
        int n = 0;
        int k;
        logic [31:0] v;
        while (!boot_done && n < 3000) begin @(negedge PCLK); n++; end
        if (!boot_done) begin
            checks++; errors++;
            $display("FAIL boot_wait: got boot_done 0 expected 1");
        end
        repeat (2) @(negedge PCLK);
        check("exp_queue_empty", exp_m.size(), 0);
        check("boot_status", {boot_done, boot_err}, {1'b1, kind != 0});
        if (kind == 2) check("timeout_cycles", hang_acc, TO);
        check("shadow", shadow, exp_shadow);
        @(posedge PCLK); #1;
        for (int i = 0; i < nsoc; i++) begin
            case ($urandom_range(0, 2))
                0: begin v = $urandom; model_cfg = v; soc_xfer(1'b1, 12'h004, v); end
                1: begin exp_soc.push_back(model_cfg); soc_xfer(1'b0, 12'h004, 32'h0); end
                default: begin
                    k = $urandom_range(0, 127);
                    exp_soc.push_back(mem[k]);
                    soc_xfer(1'b0, AW'(12'h200 + 4 * k), 32'h0);
                end
            endcase
        end
        check("shadow_after_soc", shadow, exp_shadow);
        check("soc_queue_empty", exp_soc.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int kind, f;
        xfer_t x;
        PRESETN = 1'b0; rst1_n = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pwrite = 0; s_psel = 0; s_penable = 0;
        d1_s_paddr = '0; d1_s_pwdata = '0; d1_s_pwrite = 0; d1_s_psel = 0; d1_s_penable = 0;
        for (int k = 0; k < 128; k++) mem[k] = 32'hA500_0000 + 32'(k);

        // Single word at START_WORD=10: cmd, read 0x228, idle, gap-free.
        x.addr = 12'h000; x.wr = 1'b1; x.data = 32'h1; exp1.push_back(x);
        x.addr = 12'h228; x.wr = 1'b0; x.data = mem[SW1]; exp1.push_back(x);
        x.addr = 12'h000; x.wr = 1'b1; x.data = 32'h4; exp1.push_back(x);
        repeat (3) @(posedge PCLK);
        #1 rst1_n = 1'b1;
        n = 0;
        while (!d1_done && n < 200) begin @(negedge PCLK); n++; end
        @(negedge PCLK);
        check("d1_queue_empty", exp1.size(), 0);
        check("d1_status", {d1_done, d1_err}, 2'b10);
        check("d1_shadow", d1_shadow, 32'hA500_000A);
        check("d1_psel_cycles", d1_psel_cycles, 6);
        check("d1_span_no_gaps", d1_span, 6);

        // Clean boot with fixed latency and an early SoC read pending at handover.
        start_boot(0, 0, 99);
        repeat (3) @(posedge PCLK);
        #1 exp_soc.push_back(CFG_RST);
        soc_xfer(1'b0, 12'h004, 32'h0);
        finish_boot(0, 0);
        check("pattern_shadow", shadow, {32'hA500_0003, 32'hA500_0002, 32'hA500_0001, 32'hA500_0000});

        // Timeout on the second data read.
        lat_rand = 1;
        for (int k = 0; k < 128; k++) mem[k] = $urandom;
        start_boot(2, 2, 99);
        finish_boot(2, 2);

        // Slave error on the read-mode command.
        start_boot(1, 0, 99);
        finish_boot(1, 2);

        // Reset pulsed during the third read, then a full clean boot.
        lat_rand = 0;
        start_boot(0, 0, 2);
        n = 0;
        do begin @(negedge PCLK); n++; end while (!(xfer_no == 3 && m_penable) && n < 500);
        #1 PRESETN = 1'b0;
        #1 check_reset_state();
        check("abort_queue_empty", exp_m.size(), 0);
        start_boot(0, 0, 99);
        finish_boot(0, 3);

        // Randomized boots.
        lat_rand = 1;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 128; k++) mem[k] = $urandom;
            kind = $urandom_range(0, 2);
            f = $urandom_range(0, NW + 1);
            start_boot(kind, f, 99);
            if ($urandom_range(0, 1) == 1) begin
                repeat (3) @(posedge PCLK);
                #1 exp_soc.push_back(CFG_RST);
                soc_xfer(1'b0, 12'h004, 32'h0);
            end
            finish_boot(kind, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
